// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between a controller and the PS/2 host transmitter.
// The master issues command bytes. The slave (the transmitter) reports ready, busy and completion.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends {stop, odd parity, byte} LSB first
// on device clock falls, samples the device ack and drives both lines open-drain through *_oe.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic        clk,
  input  logic        rst,
  ps2_host_tx_if.slave host,
  input  logic        ps2c_in,
  input  logic        ps2d_in,
  output logic        ps2c_oe,
  output logic        ps2d_oe
);
  // state      | meaning
  // S_IDLE     | lines released, command accepted when ready
  // S_INHIBIT  | PS2C held low for INHIBIT_CYCLES
  // S_START    | PS2D pulled low (start bit) while PS2C still low, one cycle
  // S_SEND     | data, parity, stop driven after each device clock fall
  // S_ACK      | waiting for the ack fall, PS2D sampled there
  // S_WAIT_REL | waiting for the device to release both lines
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_REL
  } state_e;

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          ack_bad_q, ack_bad_d;
  logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
  logic          ready_q, ready_d, done_q, done_d;
  logic          ack_err_q, ack_err_d, timeout_q, timeout_d;
  logic [1:0]    c_sync_q, d_sync_q;
  logic          c_d1_q;
  logic          sync_c, sync_d, fall, tmr_on, tmo;

  assign sync_c = c_sync_q[1];
  assign sync_d = d_sync_q[1];
  assign fall   = c_d1_q & ~sync_c;
  assign tmr_on = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_REL);
  assign tmo    = tmr_on && (cnt_q == '0);

  // Synchronizers reset to the idle (released-high) level so no false fall follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_d1_q   <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      c_d1_q   <= sync_c;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    ack_bad_d = ack_bad_q;
    c_oe_d    = 1'b0;
    d_oe_d    = d_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    timeout_d = 1'b0;
    if (tmr_on) cnt_d = fall ? TO_LOAD : cnt_q - CW'(1);
    unique case (state_q)
      S_IDLE: begin
        d_oe_d = 1'b0;
        if (host.tx_valid && ready_q) begin
          frame_d   = {1'b1, ~^host.tx_data, host.tx_data};
          bit_idx_d = '0;
          ack_bad_d = 1'b0;
          cnt_d     = INH_LOAD;
          c_oe_d    = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        c_oe_d = 1'b1;
        if (cnt_q == '0) begin
          d_oe_d  = 1'b1;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_START: begin
        cnt_d   = TO_LOAD;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          d_oe_d    = ~frame_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_bad_d = sync_d;
          state_d   = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (sync_c && sync_d) begin
          done_d    = 1'b1;
          ack_err_d = ack_bad_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        d_oe_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Timeout has priority over a fall or release seen in the same cycle.
    if (tmo) begin
      d_oe_d    = 1'b0;
      done_d    = 1'b1;
      ack_err_d = 1'b1;
      timeout_d = 1'b1;
      state_d   = S_IDLE;
    end
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      bit_idx_q <= '0;
      ack_bad_q <= 1'b0;
      c_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      ack_bad_q <= ack_bad_d;
      c_oe_q    <= c_oe_d;
      d_oe_q    <= d_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign ps2c_oe      = c_oe_q;
  assign ps2d_oe      = d_oe_q;
  assign host.tx_ready = ready_q;
  assign host.busy    = (state_q != S_IDLE);
  assign host.done    = done_q;
  assign host.ack_err = ack_err_q;
  assign host.timeout = timeout_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the host.
// The device's observed bits are compared with frames built from the byte, parity and stop rules.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int HP  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic last_ack_err = 1'b0;
  logic last_timeout = 1'b0;

  ps2_host_tx_if hif();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .host(hif),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: either side pulling low wins.
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  always @(negedge clk) begin
    if (hif.done === 1'b1) begin
      done_cnt     <= done_cnt + 1;
      last_ack_err <= hif.ack_err;
      last_timeout <= hif.timeout;
    end
  end

  // Reference: what the device must see, start bit first, odd parity over the byte.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    hif.tx_data  = d;
    hif.tx_valid = 1'b1;
    while (hif.tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hif.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: tx_ready=%b required 1", hif.tx_ready);
    end
    @(negedge clk);
    if (!hold) hif.tx_valid = 1'b0;
  endtask

  task automatic watch_start(output int inh, output int st);
    inh = 0;
    while (ps2c_oe === 1'b1 && ps2d_oe === 1'b0 && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    st = 0;
    while (ps2c_oe === 1'b1 && ps2d_oe === 1'b1 && st < 1000) begin
      st++;
      @(negedge clk);
    end
  endtask

  // Device: reads the start bit, then one bit per clock low phase; fall 11 is the ack.
  task automatic run_device(input int nfalls, input bit do_ack, output logic [10:0] seen);
    seen = '1;
    repeat (HP / 2) @(negedge clk);
    seen[0] = ps2d_in;
    for (int k = 0; k < 10; k++) begin
      if (k >= nfalls) return;
      dev_c_low = 1'b1;
      repeat (HP) @(negedge clk);
      seen[k+1] = ps2d_in;
      dev_c_low = 1'b0;
      repeat (HP) @(negedge clk);
    end
    if (nfalls > 10) begin
      if (do_ack) dev_d_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (HP) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (HP) @(negedge clk);
      dev_d_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 4000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({hif.tx_ready, hif.busy, hif.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: ready/busy/done=%b required 000", {hif.tx_ready, hif.busy, hif.done});
    end
    checks++;
    if ({hif.ack_err, hif.timeout} !== 2'b00) begin
      errors++;
      $display("FAIL reset_err: ack_err/timeout=%b required 00", {hif.ack_err, hif.timeout});
    end
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      errors++;
      $display("FAIL reset_oe: oe=%b required 00", {ps2c_oe, ps2d_oe});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (hif.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: tx_ready=%b required 0", hif.tx_ready);
    end
    @(negedge clk);
    checks++;
    if (hif.tx_ready !== 1'b1 || hif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready/busy=%b%b required 10", hif.tx_ready, hif.busy);
    end
  endtask

  task automatic test_frames();
    logic [7:0]  dat [8];
    bit          ack [8];
    logic [10:0] seen, expv;
    int          inh, st, prev;
    dat[0] = 8'hED; ack[0] = 1'b1;
    dat[1] = 8'hF4; ack[1] = 1'b1;
    dat[2] = 8'h00; ack[2] = 1'b0;
    for (int i = 3; i < 8; i++) begin
      dat[i] = 8'($urandom_range(0, 255));
      ack[i] = bit'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) begin
      prev = done_cnt;
      expv = exp_frame(dat[i]);
      start_tx(dat[i], 1'b0);
      checks++;
      if (hif.busy !== 1'b1 || hif.tx_ready !== 1'b0) begin
        errors++;
        $display("FAIL frame_busy %02h: busy/ready=%b%b required 10", dat[i], hif.busy, hif.tx_ready);
      end
      watch_start(inh, st);
      checks++;
      if (inh != INH) begin
        errors++;
        $display("FAIL frame_inhibit %02h: %0d cycles required %0d", dat[i], inh, INH);
      end
      checks++;
      if (st != 1) begin
        errors++;
        $display("FAIL frame_start %02h: %0d cycles required 1", dat[i], st);
      end
      run_device(11, ack[i], seen);
      checks++;
      if (seen !== expv) begin
        errors++;
        $display("FAIL frame_bits %02h: seen=%b required %b", dat[i], seen, expv);
      end
      wait_done(prev);
      checks++;
      if (done_cnt != prev + 1) begin
        errors++;
        $display("FAIL frame_done %02h: pulses=%0d required 1", dat[i], done_cnt - prev);
      end
      checks++;
      if (last_ack_err !== logic'(!ack[i]) || last_timeout !== 1'b0) begin
        errors++;
        $display("FAIL frame_ack %02h: ack_err/timeout=%b%b required %b0", dat[i],
                 last_ack_err, last_timeout, !ack[i]);
      end
      checks++;
      if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
        errors++;
        $display("FAIL frame_release %02h: oe=%b required 00", dat[i], {ps2c_oe, ps2d_oe});
      end
    end
  endtask

  task automatic test_timeout();
    int inh, st, n;
    start_tx(8'($urandom_range(0, 255)), 1'b0);
    watch_start(inh, st);
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b01) begin
      errors++;
      $display("FAIL to_clock_release: oe=%b required 01", {ps2c_oe, ps2d_oe});
    end
    n = 0;
    while (hif.done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL to_latency: %0d cycles required %0d", n, TMO);
    end
    checks++;
    if ({hif.done, hif.ack_err, hif.timeout} !== 3'b111) begin
      errors++;
      $display("FAIL to_flags: done/ack_err/timeout=%b required 111", {hif.done, hif.ack_err, hif.timeout});
    end
    checks++;
    if ({ps2c_oe, ps2d_oe, hif.tx_ready} !== 3'b000) begin
      errors++;
      $display("FAIL to_release: oe/ready=%b required 000", {ps2c_oe, ps2d_oe, hif.tx_ready});
    end
    @(negedge clk);
    checks++;
    if ({hif.done, hif.tx_ready} !== 2'b01) begin
      errors++;
      $display("FAIL to_after: done/ready=%b required 01", {hif.done, hif.tx_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  d0;
    logic [10:0] seen, expv;
    int          inh, st, n, prev;
    d0 = 8'($urandom_range(0, 255));
    if (d0 == 8'hAA) d0 = 8'h55;
    start_tx(d0, 1'b1);
    hif.tx_data = 8'hAA;
    watch_start(inh, st);
    expv = exp_frame(d0);
    run_device(11, 1'b1, seen);
    checks++;
    if (seen !== expv) begin
      errors++;
      $display("FAIL b2b_first_bits: seen=%b required %b", seen, expv);
    end
    n = 0;
    while (hif.done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hif.done !== 1'b1 || hif.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle: done/ready=%b%b required 10", hif.done, hif.tx_ready);
    end
    @(negedge clk);
    checks++;
    if (hif.tx_ready !== 1'b1 || ps2c_oe !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after_done: ready/c_oe=%b%b required 10", hif.tx_ready, ps2c_oe);
    end
    @(negedge clk);
    checks++;
    if (ps2c_oe !== 1'b1 || hif.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: c_oe/ready=%b%b required 10", ps2c_oe, hif.tx_ready);
    end
    hif.tx_valid = 1'b0;
    prev = done_cnt;
    watch_start(inh, st);
    checks++;
    if (inh != INH) begin
      errors++;
      $display("FAIL b2b_second_inhibit: %0d cycles required %0d", inh, INH);
    end
    expv = exp_frame(8'hAA);
    run_device(11, 1'b1, seen);
    checks++;
    if (seen !== expv) begin
      errors++;
      $display("FAIL b2b_second_bits: seen=%b required %b", seen, expv);
    end
    wait_done(prev);
    checks++;
    if (done_cnt != prev + 1 || last_ack_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: pulses=%0d ack_err=%b required 1 0", done_cnt - prev, last_ack_err);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0]  d;
    logic [10:0] seen, expv;
    int          inh, st, prev;
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    expv = exp_frame(d);
    prev = done_cnt;
    start_tx(d, 1'b0);
    watch_start(inh, st);
    run_device(4, 1'b0, seen);
    checks++;
    if (seen[4:0] !== expv[4:0]) begin
      errors++;
      $display("FAIL mid_bits: seen=%b required %b", seen[4:0], expv[4:0]);
    end
    checks++;
    if (ps2d_oe !== 1'b1 || hif.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_driving: d_oe/busy=%b%b required 11", ps2d_oe, hif.busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ps2c_oe, ps2d_oe} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_release: oe=%b required 00", {ps2c_oe, ps2d_oe});
    end
    checks++;
    if ({hif.busy, hif.tx_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_status: busy/ready=%b required 00", {hif.busy, hif.tx_ready});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (hif.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: tx_ready=%b required 1", hif.tx_ready);
    end
    checks++;
    if (done_cnt != prev) begin
      errors++;
      $display("FAIL mid_no_done: pulses=%0d required 0", done_cnt - prev);
    end
  endtask

  initial begin
    hif.tx_valid = 1'b0;
    hif.tx_data  = 8'h00;
    test_reset();
    test_frames();
    test_timeout();
    test_back_to_back();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
